key_led_mode: RTL and testbench

//   Downstream consumer of the key debouncer. Takes the debounced key level,

---
 rtl/key_led_mode.sv | 204 ++++++++++++++++++++
 tb/tb_key_led_mode.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_led_mode.sv
// -----------------------------------------------------------------------------
// key_led_mode
//   Steps the board LED through five display modes on every key press
//   (a 1->0 edge of the debounced key level):
//     OFF -> ON -> SLOW blink -> FAST blink -> BREATH (PWM fade) -> OFF ...
//   Single clock domain; the mode and the LED are both registered.
//
// Ports
//   sclk     in   1  system clock, rising-edge
//   s_rst    in   1  asynchronous reset, active-high
//   key_dbn  in   1  debounced key level, same clock domain; 0 = pressed
//   mode     out  3  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 BREATH
//   led      out  1  LED drive, 1 = lit (registered)
// -----------------------------------------------------------------------------
module key_led_mode #(
  parameter int BLINK_SLOW  = 25_000_000,
  parameter int BLINK_FAST  = 5_000_000,
  parameter int PWM_PERIOD  = 1_000,
  parameter int BREATH_STEP = 25_000,
  parameter int CNT_W       = 32
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       key_dbn,
  output logic [2:0] mode,
  output logic       led
);

  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);

  localparam logic [CNT_W-1:0]  SLOW_LIM  = CNT_W'(BLINK_SLOW - 1);
  localparam logic [CNT_W-1:0]  FAST_LIM  = CNT_W'(BLINK_FAST - 1);
  localparam logic [CNT_W-1:0]  PWM_LIM   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0]  STEP_LIM  = CNT_W'(BREATH_STEP - 1);
  localparam logic [DUTY_W-1:0] DUTY_TOP1 = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_SLOW   = 3'd2,
    MODE_FAST   = 3'd3,
    MODE_BREATH = 3'd4
  } mode_t;

  mode_t              state_r;
  mode_t              state_next_s;
  logic               key_d1_r;
  logic               armed_r;
  logic               press_s;
  logic [CNT_W-1:0]   half_cnt_r;
  logic [CNT_W-1:0]   half_cnt_next_s;
  logic [CNT_W-1:0]   half_lim_s;
  logic               blink_ph_r;
  logic               blink_ph_next_s;
  logic [CNT_W-1:0]   pwm_cnt_r;
  logic [CNT_W-1:0]   pwm_cnt_next_s;
  logic [CNT_W-1:0]   step_cnt_r;
  logic [CNT_W-1:0]   step_cnt_next_s;
  logic [DUTY_W-1:0]  duty_r;
  logic [DUTY_W-1:0]  duty_next_s;
  logic               dir_down_r;
  logic               dir_down_next_s;
  logic               led_r;
  logic               led_next_s;

  // The key level seen at reset release is the baseline: armed_r masks the
  // first edge after reset, so a key already held low then does not count as
  // a press until it is released and pressed again.
  assign press_s = key_d1_r & ~key_dbn & armed_r;

  // Half-period limit for the active blink mode.
  always_comb begin
    half_lim_s = FAST_LIM;
    if (state_r == MODE_SLOW) begin
      half_lim_s = SLOW_LIM;
    end else begin
      half_lim_s = FAST_LIM;
    end
  end

  // Mode FSM next state: one advance per press; stray encodings fall back to OFF.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MODE_OFF: begin
        if (press_s) state_next_s = MODE_ON;
        else         state_next_s = MODE_OFF;
      end
      MODE_ON: begin
        if (press_s) state_next_s = MODE_SLOW;
        else         state_next_s = MODE_ON;
      end
      MODE_SLOW: begin
        if (press_s) state_next_s = MODE_FAST;
        else         state_next_s = MODE_SLOW;
      end
      MODE_FAST: begin
        if (press_s) state_next_s = MODE_BREATH;
        else         state_next_s = MODE_FAST;
      end
      MODE_BREATH: begin
        if (press_s) state_next_s = MODE_OFF;
        else         state_next_s = MODE_BREATH;
      end
      default: state_next_s = MODE_OFF;
    endcase
  end

  // Counter next state. The defaults are the cleared state, which is what a
  // press produces and what every counter not used by the mode is held at.
  always_comb begin
    half_cnt_next_s = '0;
    blink_ph_next_s = 1'b1;
    pwm_cnt_next_s  = '0;
    step_cnt_next_s = '0;
    duty_next_s     = '0;
    dir_down_next_s = 1'b0;
    if (press_s) begin
      // press wins over any wrap in the same cycle: keep the cleared defaults
    end else begin
      case (state_r)
        MODE_SLOW, MODE_FAST: begin
          if (half_cnt_r == half_lim_s) begin
            half_cnt_next_s = '0;
            blink_ph_next_s = ~blink_ph_r;
          end else begin
            half_cnt_next_s = half_cnt_r + CNT_W'(1);
            blink_ph_next_s = blink_ph_r;
          end
        end
        MODE_BREATH: begin
          if (pwm_cnt_r == PWM_LIM) begin
            pwm_cnt_next_s = '0;
          end else begin
            pwm_cnt_next_s = pwm_cnt_r + CNT_W'(1);
          end
          if (step_cnt_r == STEP_LIM) begin
            step_cnt_next_s = '0;
            // Direction turns in the same step that reaches an end, so the
            // extremes are held for exactly one step.
            if (dir_down_r) begin
              duty_next_s     = duty_r - DUTY_ONE;
              dir_down_next_s = (duty_r != DUTY_ONE);
            end else begin
              duty_next_s     = duty_r + DUTY_ONE;
              dir_down_next_s = (duty_r == DUTY_TOP1);
            end
          end else begin
            step_cnt_next_s = step_cnt_r + CNT_W'(1);
            duty_next_s     = duty_r;
            dir_down_next_s = dir_down_r;
          end
        end
        default: begin
          // OFF / ON use no counters: keep the cleared defaults
        end
      endcase
    end
  end

  // LED drive from the pre-edge mode and counters.
  always_comb begin
    led_next_s = 1'b0;
    case (state_r)
      MODE_OFF:             led_next_s = 1'b0;
      MODE_ON:              led_next_s = 1'b1;
      MODE_SLOW, MODE_FAST: led_next_s = blink_ph_r;
      MODE_BREATH:          led_next_s = (pwm_cnt_r < CNT_W'(duty_r));
      default:              led_next_s = 1'b0;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_r    <= MODE_OFF;
      key_d1_r   <= 1'b1;
      armed_r    <= 1'b0;
      half_cnt_r <= '0;
      blink_ph_r <= 1'b1;
      pwm_cnt_r  <= '0;
      step_cnt_r <= '0;
      duty_r     <= '0;
      dir_down_r <= 1'b0;
      led_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      key_d1_r   <= key_dbn;
      armed_r    <= 1'b1;
      half_cnt_r <= half_cnt_next_s;
      blink_ph_r <= blink_ph_next_s;
      pwm_cnt_r  <= pwm_cnt_next_s;
      step_cnt_r <= step_cnt_next_s;
      duty_r     <= duty_next_s;
      dir_down_r <= dir_down_next_s;
      led_r      <= led_next_s;
    end
  end

  assign mode = state_r;
  assign led  = led_r;

endmodule

// File: tb/tb_key_led_mode.sv
// -----------------------------------------------------------------------------
// tb_key_led_mode
//   Directed bench for key_led_mode with small timing parameters
//   (BLINK_SLOW=4, BLINK_FAST=2, PWM_PERIOD=4, BREATH_STEP=4).
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_key_led_mode;

  logic       sclk;
  logic       s_rst;
  logic       key_dbn;
  logic [2:0] mode;
  logic       led;

  int tests_run;
  int tests_failed;

  key_led_mode #(
    .BLINK_SLOW  (4),
    .BLINK_FAST  (2),
    .PWM_PERIOD  (4),
    .BREATH_STEP (4),
    .CNT_W       (32)
  ) dut (
    .sclk    (sclk),
    .s_rst   (s_rst),
    .key_dbn (key_dbn),
    .mode    (mode),
    .led     (led)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // key low across one edge, then released
  task automatic press();
    key_dbn = 1'b0;
    tick();
    key_dbn = 1'b1;
  endtask

  task automatic test_reset();
    s_rst   = 1'b1;
    key_dbn = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (mode !== 3'd0 || led !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d mode=%0d led=%b expected mode=0 led=0", i, mode, led);
      end
    end
    s_rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests_run++;
      if (mode !== 3'd0 || led !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d mode=%0d led=%b expected mode=0 led=0", i, mode, led);
      end
    end
  endtask

  task automatic test_press_hold();
    key_dbn = 1'b0;
    tick();
    tests_run++;
    if (mode !== 3'd1 || led !== 1'b0) begin
      tests_failed++;
      $display("FAIL press_edge mode=%0d led=%b expected mode=1 led=0", mode, led);
    end
    for (int i = 0; i < 29; i++) begin
      tick();
      tests_run++;
      if (mode !== 3'd1 || led !== 1'b1) begin
        tests_failed++;
        $display("FAIL press_held cyc=%0d mode=%0d led=%b expected mode=1 led=1", i, mode, led);
      end
    end
    key_dbn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (mode !== 3'd1 || led !== 1'b1) begin
        tests_failed++;
        $display("FAIL release cyc=%0d mode=%0d led=%b expected mode=1 led=1", i, mode, led);
      end
    end
  endtask

  task automatic test_blink();
    logic exp_led;
    press();
    tests_run++;
    if (mode !== 3'd2) begin
      tests_failed++;
      $display("FAIL slow_entry mode=%0d expected 2", mode);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_led = (((k - 1) / 4) % 2 == 0);
      tests_run++;
      if (led !== exp_led || mode !== 3'd2) begin
        tests_failed++;
        $display("FAIL slow_blink k=%0d led=%b mode=%0d expected led=%b mode=2", k, led, mode, exp_led);
      end
    end
    press();
    tests_run++;
    if (mode !== 3'd3) begin
      tests_failed++;
      $display("FAIL fast_entry mode=%0d expected 3", mode);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_led = (((k - 1) / 2) % 2 == 0);
      tests_run++;
      if (led !== exp_led || mode !== 3'd3) begin
        tests_failed++;
        $display("FAIL fast_blink k=%0d led=%b mode=%0d expected led=%b mode=3", k, led, mode, exp_led);
      end
    end
  endtask

  task automatic test_breath();
    int   duty_tbl [12] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};
    int   ones;
    logic exp_led;
    press();
    tests_run++;
    if (mode !== 3'd4) begin
      tests_failed++;
      $display("FAIL breath_entry mode=%0d expected 4", mode);
    end
    for (int m = 0; m < 12; m++) begin
      ones = 0;
      for (int p = 0; p < 4; p++) begin
        tick();
        exp_led = (p < duty_tbl[m]);
        if (led === 1'b1) ones++;
        tests_run++;
        if (led !== exp_led) begin
          tests_failed++;
          $display("FAIL breath_pwm frame=%0d pos=%0d led=%b expected %b", m, p, led, exp_led);
        end
      end
      tests_run++;
      if (ones != duty_tbl[m]) begin
        tests_failed++;
        $display("FAIL breath_frame frame=%0d lit=%0d expected %0d", m, ones, duty_tbl[m]);
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_led;
    press();
    tests_run++;
    if (mode !== 3'd0) begin
      tests_failed++;
      $display("FAIL wrap_mode mode=%0d expected 0", mode);
    end
    tick();
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_led led=%b expected 0", led);
    end
    press();
    tick();
    press();
    tests_run++;
    if (mode !== 3'd2) begin
      tests_failed++;
      $display("FAIL wrap_slow_entry mode=%0d expected 2", mode);
    end
    // half_cnt reaches 3 after three edges, so the next edge is a blink wrap
    repeat (3) tick();
    press();
    tests_run++;
    if (mode !== 3'd3) begin
      tests_failed++;
      $display("FAIL press_on_wrap mode=%0d expected 3", mode);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_led = (k <= 2);
      tests_run++;
      if (led !== exp_led || mode !== 3'd3) begin
        tests_failed++;
        $display("FAIL wrap_cleared k=%0d led=%b mode=%0d expected led=%b mode=3", k, led, mode, exp_led);
      end
    end
  endtask

  task automatic test_reset_mid_breath();
    key_dbn = 1'b0;
    tick();
    tests_run++;
    if (mode !== 3'd4) begin
      tests_failed++;
      $display("FAIL mid_breath_entry mode=%0d expected 4", mode);
    end
    repeat (9) tick();
    #2;
    s_rst = 1'b1;
    #1;
    tests_run++;
    if (mode !== 3'd0 || led !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset mode=%0d led=%b expected mode=0 led=0", mode, led);
    end
    repeat (3) tick();
    s_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (mode !== 3'd0 || led !== 1'b0) begin
        tests_failed++;
        $display("FAIL held_after_reset cyc=%0d mode=%0d led=%b expected mode=0 led=0", i, mode, led);
      end
    end
    key_dbn = 1'b1;
    tick();
    press();
    tests_run++;
    if (mode !== 3'd1) begin
      tests_failed++;
      $display("FAIL new_press mode=%0d expected 1", mode);
    end
    tick();
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL new_press_led led=%b expected 1", led);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_press_hold();
    test_blink();
    test_breath();
    test_wrap();
    test_reset_mid_breath();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
